// File: rtl/timer_bank.sv
// timer_bank: a bank of N_CH independent prescaled timer channels.
//
// Each channel runs IDLE -> RUN on a start pulse. In RUN, a prescaler counts
// 0..scale and produces one tick per (scale+1) cycles. Each tick advances the
// main counter, which wraps to 0 once it has reached period. A wrap in one-shot
// mode parks the channel in DONE. A wrap in periodic mode keeps the channel in
// RUN. The configuration inputs are sampled live every cycle.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-high reset
//   en        in   [N_CH]        per-channel enable (0 forces IDLE, clears count)
//   start     in   [N_CH]        per-channel start/restart pulse
//   oneshot   in   [N_CH]        1 = one-shot, 0 = periodic
//   scale     in   [N_CH*PRE_W]  per-channel prescale limit
//   period    in   [N_CH*CNT_W]  per-channel terminal count
//   cmp       in   [N_CH*CNT_W]  per-channel compare value
//   flag_clr  in   [N_CH]        clear sticky flags (a same-cycle set wins)
//   cntr      out  [N_CH*CNT_W]  per-channel counter value
//   running   out  [N_CH]        channel is in RUN
//   ovf_pulse out  [N_CH]        one-cycle wrap strobe
//   ovf_flag  out  [N_CH]        sticky wrap flag
//   cmp_flag  out  [N_CH]        sticky compare-match flag
//   irq       out  1             OR of all sticky flags
module timer_bank #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned CNT_W = 16,
  parameter int unsigned PRE_W = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_CH-1:0]         en,
  input  logic [N_CH-1:0]         start,
  input  logic [N_CH-1:0]         oneshot,
  input  logic [N_CH*PRE_W-1:0]   scale,
  input  logic [N_CH*CNT_W-1:0]   period,
  input  logic [N_CH*CNT_W-1:0]   cmp,
  input  logic [N_CH-1:0]         flag_clr,
  output logic [N_CH*CNT_W-1:0]   cntr,
  output logic [N_CH-1:0]         running,
  output logic [N_CH-1:0]         ovf_pulse,
  output logic [N_CH-1:0]         ovf_flag,
  output logic [N_CH-1:0]         cmp_flag,
  output logic                    irq
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    state_e             r_state, w_state_d;
    logic [PRE_W-1:0]   r_pre, w_pre_d, w_scale;
    logic [CNT_W-1:0]   r_cntr, w_cntr_d, w_period, w_cmp;
    logic               r_running, r_ovf_pulse, r_ovf_flag, r_cmp_flag;
    logic               w_ovf_set, w_cmp_set;

    assign w_scale  = scale[g*PRE_W +: PRE_W];
    assign w_period = period[g*CNT_W +: CNT_W];
    assign w_cmp    = cmp[g*CNT_W +: CNT_W];

    always_comb begin
      w_state_d = r_state;
      w_pre_d   = r_pre;
      w_cntr_d  = r_cntr;
      w_ovf_set = 1'b0;
      w_cmp_set = 1'b0;
      if (!en[g]) begin
        w_state_d = StIdle;
        w_pre_d   = '0;
        w_cntr_d  = '0;
      end else if (start[g]) begin
        // Start overrides any coincident tick, so a wrap on this edge is dropped.
        w_state_d = StRun;
        w_pre_d   = '0;
        w_cntr_d  = '0;
        w_cmp_set = (w_cmp == '0);
      end else if (r_state == StRun) begin
        // A >= test (not ==) so that lowering scale/period mid-count takes effect at once.
        if (r_pre >= w_scale) begin
          w_pre_d = '0;
          if (r_cntr >= w_period) begin
            w_cntr_d  = '0;
            w_ovf_set = 1'b1;
            if (oneshot[g]) begin
              w_state_d = StDone;
            end
          end else begin
            w_cntr_d = r_cntr + CNT_W'(1);
          end
          w_cmp_set = (w_cntr_d == w_cmp);
        end else begin
          w_pre_d = r_pre + PRE_W'(1);
        end
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_state     <= StIdle;
        r_pre       <= '0;
        r_cntr      <= '0;
        r_running   <= 1'b0;
        r_ovf_pulse <= 1'b0;
        r_ovf_flag  <= 1'b0;
        r_cmp_flag  <= 1'b0;
      end else begin
        r_state     <= w_state_d;
        r_pre       <= w_pre_d;
        r_cntr      <= w_cntr_d;
        r_running   <= (w_state_d == StRun);
        r_ovf_pulse <= w_ovf_set;
        // A set in the same cycle as a clear wins.
        r_ovf_flag  <= w_ovf_set | (r_ovf_flag & ~flag_clr[g]);
        r_cmp_flag  <= w_cmp_set | (r_cmp_flag & ~flag_clr[g]);
      end
    end

    assign cntr[g*CNT_W +: CNT_W] = r_cntr;
    assign running[g]             = r_running;
    assign ovf_pulse[g]           = r_ovf_pulse;
    assign ovf_flag[g]            = r_ovf_flag;
    assign cmp_flag[g]            = r_cmp_flag;
  end

  assign irq = |(ovf_flag | cmp_flag);

endmodule

// File: tb/tb_timer_bank.sv
module tb_timer_bank;
  localparam int N  = 4;
  localparam int CW = 16;
  localparam int PW = 15;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      en, start, oneshot, flag_clr;
  logic [N*PW-1:0]   scale;
  logic [N*CW-1:0]   period, cmp;
  logic [N*CW-1:0]   cntr;
  logic [N-1:0]      running, ovf_pulse, ovf_flag, cmp_flag;
  logic              irq;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: st 0 = idle, 1 = run, 2 = done.
  int m_cnt [N];
  int m_pre [N];
  int m_st  [N];
  bit m_pls [N];
  bit m_of  [N];
  bit m_cf  [N];

  timer_bank #(.N_CH(N), .CNT_W(CW), .PRE_W(PW)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .start     (start),
    .oneshot   (oneshot),
    .scale     (scale),
    .period    (period),
    .cmp       (cmp),
    .flag_clr  (flag_clr),
    .cntr      (cntr),
    .running   (running),
    .ovf_pulse (ovf_pulse),
    .ovf_flag  (ovf_flag),
    .cmp_flag  (cmp_flag),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0; m_pre[i] = 0; m_st[i] = 0;
      m_pls[i] = 0; m_of[i] = 0; m_cf[i] = 0;
    end
  endtask

  // One clock of behaviour, from the inputs currently applied.
  task automatic model_step();
    int sc, pd, cp;
    bit set_o, set_c;
    for (int i = 0; i < N; i++) begin
      sc = int'(scale[i*PW +: PW]);
      pd = int'(period[i*CW +: CW]);
      cp = int'(cmp[i*CW +: CW]);
      set_o = 0;
      set_c = 0;
      if (!en[i]) begin
        m_st[i] = 0; m_cnt[i] = 0; m_pre[i] = 0;
      end else if (start[i]) begin
        m_st[i] = 1; m_cnt[i] = 0; m_pre[i] = 0;
        set_c = (cp == 0);
      end else if (m_st[i] == 1) begin
        if (m_pre[i] < sc) begin
          m_pre[i]++;
        end else begin
          m_pre[i] = 0;
          m_cnt[i] = (m_cnt[i] >= pd) ? 0 : (m_cnt[i] + 1) % 65536;
          if (m_cnt[i] == 0) begin
            set_o = 1;
            if (oneshot[i]) m_st[i] = 2;
          end
          set_c = (m_cnt[i] == cp);
        end
      end
      m_pls[i] = set_o;
      m_of[i]  = set_o || (m_of[i] && !flag_clr[i]);
      m_cf[i]  = set_c || (m_cf[i] && !flag_clr[i]);
    end
  endtask

  task automatic check_all(input string tag);
    logic [N*CW-1:0] e_cnt;
    logic [N-1:0]    e_run, e_pls, e_of, e_cf;
    for (int i = 0; i < N; i++) begin
      e_cnt[i*CW +: CW] = CW'(m_cnt[i]);
      e_run[i] = (m_st[i] == 1);
      e_pls[i] = m_pls[i];
      e_of[i]  = m_of[i];
      e_cf[i]  = m_cf[i];
    end
    chk({tag, ".cntr"},      64'(cntr),      64'(e_cnt));
    chk({tag, ".running"},   64'(running),   64'(e_run));
    chk({tag, ".ovf_pulse"}, 64'(ovf_pulse), 64'(e_pls));
    chk({tag, ".ovf_flag"},  64'(ovf_flag),  64'(e_of));
    chk({tag, ".cmp_flag"},  64'(cmp_flag),  64'(e_cf));
    chk({tag, ".irq"},       64'(irq),       64'(|(e_of | e_cf)));
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic set_ch(input int i, input int sc, input int pd, input int cp, input bit os);
    scale[i*PW +: PW]  = PW'(sc);
    period[i*CW +: CW] = CW'(pd);
    cmp[i*CW +: CW]    = CW'(cp);
    oneshot[i]         = os;
  endtask

  function automatic int ch_cnt(input int i);
    return int'(cntr[i*CW +: CW]);
  endfunction

  initial begin
    int per [N];
    reset = 1'b1; en = '0; start = '0; oneshot = '0; flag_clr = '0;
    scale = '0; period = '0; cmp = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    reset = 1'b0;

    // Channel 0: scale 2, period 3, periodic -> 12-cycle wrap cadence.
    set_ch(0, 2, 3, 100, 0);
    en[0] = 1'b1; start[0] = 1'b1;
    tick("ch0_start");
    start[0] = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      tick("ch0_run");
      if (k == 3)  chk("ch0_cnt_e3", 64'(ch_cnt(0)), 64'd1);
      if (k == 6)  chk("ch0_cnt_e6", 64'(ch_cnt(0)), 64'd2);
      if (k == 9)  chk("ch0_cnt_e9", 64'(ch_cnt(0)), 64'd3);
      if (k == 12 || k == 24) chk("ch0_wrap_pulse", 64'(ovf_pulse[0]), 64'd1);
      if (k == 13) chk("ch0_pulse_1cyc", 64'(ovf_pulse[0]), 64'd0);
    end

    // Channel 1: one-shot, scale 0, period 4.
    set_ch(1, 0, 4, 100, 1);
    en[1] = 1'b1; start[1] = 1'b1;
    tick("ch1_start");
    start[1] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick("ch1_run");
      if (k == 5)  chk("ch1_pulse_e5", 64'(ovf_pulse[1]), 64'd1);
      if (k == 6)  chk("ch1_done_run", 64'(running[1]), 64'd0);
      if (k == 10) chk("ch1_done_cnt", 64'(ch_cnt(1)), 64'd0);
      if (k > 5)   chk("ch1_no_pulse", 64'(ovf_pulse[1]), 64'd0);
    end

    // Channel 2: compare flag, clear, and clear coincident with a set.
    set_ch(2, 0, 5, 2, 0);
    en[2] = 1'b1; start[2] = 1'b1;
    tick("ch2_start");
    start[2] = 1'b0;
    tick("ch2_e1");
    tick("ch2_e2");
    chk("ch2_cmp_set", 64'(cmp_flag[2]), 64'd1);
    chk("ch2_irq", 64'(irq), 64'd1);
    flag_clr[2] = 1'b1;
    tick("ch2_clr");
    flag_clr[2] = 1'b0;
    chk("ch2_cmp_clr", 64'(cmp_flag[2]), 64'd0);
    for (int k = 0; k < 4; k++) tick("ch2_wait");
    chk("ch2_cmp_still0", 64'(cmp_flag[2]), 64'd0);
    flag_clr[2] = 1'b1;
    tick("ch2_clr_vs_set");
    flag_clr[2] = 1'b0;
    chk("ch2_set_wins", 64'(cmp_flag[2]), 64'd1);

    // Channel 3: lower period below the current count.
    set_ch(3, 0, 10, 100, 0);
    en[3] = 1'b1; start[3] = 1'b1;
    tick("ch3_start");
    start[3] = 1'b0;
    for (int k = 0; k < 7; k++) tick("ch3_run");
    chk("ch3_cnt7", 64'(ch_cnt(3)), 64'd7);
    period[3*CW +: CW] = CW'(3);
    tick("ch3_lowered");
    chk("ch3_wrap_pulse", 64'(ovf_pulse[3]), 64'd1);
    chk("ch3_wrap_cnt", 64'(ch_cnt(3)), 64'd0);

    // All channels with distinct cadences.
    set_ch(0, 1, 2, 100, 0); per[0] = 6;
    set_ch(1, 0, 6, 100, 0); per[1] = 7;
    set_ch(2, 2, 2, 100, 0); per[2] = 9;
    set_ch(3, 3, 1, 100, 0); per[3] = 8;
    en = '1; start = '1;
    tick("all_start");
    start = '0;
    for (int k = 1; k <= 72; k++) begin
      tick("all_run");
      for (int i = 0; i < N; i++)
        chk($sformatf("cadence_ch%0d_k%0d", i, k), 64'(ovf_pulse[i]), 64'((k % per[i]) == 0));
    end
    tick("pre_en_drop");
    en[1] = 1'b0;
    tick("en1_drop");
    chk("en1_cnt0", 64'(ch_cnt(1)), 64'd0);
    chk("en1_running", 64'(running), 64'b1101);

    // Async reset mid-count with flags set.
    en[1] = 1'b1;
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all("async_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 5; k++) tick("post_reset_idle");
    start[0] = 1'b1;
    tick("resume");
    start[0] = 1'b0;
    chk("resume_running", 64'(running[0]), 64'd1);

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 7) == 0)
        set_ch(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      for (int i = 0; i < N; i++) begin
        en[i]       = ($urandom_range(0, 15) != 0);
        start[i]    = ($urandom_range(0, 15) == 0);
        flag_clr[i] = ($urandom_range(0, 7) == 0);
      end
      tick("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/timer_bank.md
TIMER_BANK -- requirements
Module: timer_bank

Interface
REQ-001 SHALL have parameters: N_CH, default 4, number of independent timer channels.
REQ-002 SHALL have parameters: CNT_W, default 16, main counter width; PRE_W, default 15, prescaler width.
REQ-003 SHALL have ports: clk  in  1  clock, all state updates on rising edge.
REQ-004 SHALL have ports: reset  in  1  asynchronous, active-high; clock clk.
REQ-005 SHALL have ports: en  in  N_CH  per-channel enable.
REQ-006 SHALL have ports: start  in  N_CH  per-channel start/restart pulse.
REQ-007 SHALL have ports: oneshot  in  N_CH  per-channel mode: 1 = one-shot, 0 = periodic.
REQ-008 SHALL have ports: scale  in  N_CH*PRE_W  per-channel prescale limit, channel i at bits [i*PRE_W +: PRE_W].
REQ-009 SHALL have ports: period  in  N_CH*CNT_W  per-channel terminal count; cmp  in  N_CH*CNT_W  per-channel compare value.
REQ-010 SHALL have ports: flag_clr  in  N_CH  per-channel clear of sticky flags.
REQ-011 SHALL have ports: cntr  out  N_CH*CNT_W  per-channel counter value; running  out  N_CH  channel in RUN.
REQ-012 SHALL have ports: ovf_pulse  out  N_CH  one-cycle wrap strobe; ovf_flag, cmp_flag  out  N_CH  sticky flags; irq  out  1  OR of all sticky flags.

Function
REQ-013 SHALL give each channel states IDLE, RUN and DONE, with no cross-channel interaction except irq.
REQ-014 SHALL, with en=0, force IDLE with cntr=0 and prescaler=0 at the next edge; start is ignored.
REQ-015 SHALL, on start=1 with en=1 in any state, enter RUN with cntr=0 and prescaler=0; start in RUN restarts the channel.
REQ-016 SHALL, in RUN, count the prescaler 0..scale; a tick occurs in the cycle where prescaler>=scale, and the prescaler then returns to 0.
REQ-017 SHALL, for scale=0, tick every cycle.
REQ-018 SHALL, on a tick, wrap cntr to 0 if cntr>=period, otherwise increment cntr by 1; arithmetic is modulo 2^CNT_W.
REQ-019 SHALL wrap at the next tick if period is lowered below cntr while running.
REQ-020 SHALL make wrap period = (scale+1)*(period+1) cycles.
REQ-021 SHALL, on wrap, register ovf_pulse=1 for exactly one cycle and set ovf_flag.
REQ-022 SHALL, on wrap in one-shot mode, go to DONE with cntr held at 0 and running=0.
REQ-023 SHALL, on wrap in periodic mode, remain in RUN.
REQ-024 SHALL set cmp_flag on the edge at which cntr is loaded with a value equal to cmp, including wrap to 0 when cmp=0, and including the load to 0 on start when cmp=0.
REQ-025 SHALL, when flag_clr and a flag-set event occur in the same cycle, leave the flag set; set has priority.
REQ-026 SHALL, when start and a wrap tick coincide, apply start: no ovf_pulse and cntr=0.
REQ-027 SHALL drive cntr, running, ovf_pulse and the flags from registers; irq is combinational OR of ovf_flag|cmp_flag.
REQ-028 SHALL sample configuration inputs every cycle with no shadow registers.

Reset
REQ-029 SHALL, while reset=1, hold all channels IDLE, with cntr, prescaler, running, ovf_pulse, ovf_flag and cmp_flag at 0 and irq=0, regardless of clk.
REQ-030 SHALL abort any running or one-shot operation on reset asserted mid-count, with no ovf_pulse on release; after release, channels stay IDLE until start.

Verification
REQ-031 SHALL cover: ch0 scale=2, period=3, periodic, start pulse -> cntr 1/2/3 at edges 3/6/9 after start, wrap to 0 with ovf_pulse at edge 12, repeating every 12 cycles.
REQ-032 SHALL cover: ch1 scale=0, period=4, oneshot=1, start -> ovf_pulse once at edge 5, then DONE, running=0, cntr=0; no further pulses until a new start.
REQ-033 SHALL cover: ch2 cmp=2, period=5, scale=0 -> cmp_flag set at edge 2 and irq=1; flag_clr pulse -> flag cleared; flag_clr coincident with the next compare event -> flag stays 1.
REQ-034 SHALL cover: ch3 period changed 10->3 while cntr=7 -> wrap at next tick with ovf_pulse.
REQ-035 SHALL cover: all 4 channels running with different scale/period values -> each wraps at its own (scale+1)*(period+1) cadence; en[1]=0 mid-count -> only ch1 returns to cntr=0 in IDLE.
REQ-036 SHALL cover: reset asserted asynchronously mid-count with flags set -> all outputs 0 immediately; after release, start required to resume.
